register_file: RTL

Parametrised multi-port general-purpose register file for the CPU datapath; successor of the fixed 2-read/1-write, 32x32 register file. It provides NUM_READ combinational read ports and NUM_WRITE posedge write ports, with register 0 hardwired to zero. A post-reset clear sweep zeroes every entry and holds `ready` low until the sweep is complete. Optional write-to-read bypass lets the decode stage see a same-cycle writeback.

---
 rtl/register_file_pkg.sv | 17 +
 rtl/register_file_if.sv | 40 ++++
 rtl/register_file_read_port.sv | 47 ++++
 rtl/register_file.sv | 92 +++++++++
 4 files changed

// File: rtl/register_file_pkg.sv
// Shared constants and types for the multi-port register file.
// Control-level definitions live here so every file agrees on polarity.
package register_file_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_ADDR_WIDTH = 5;

  localparam logic READ_ENABLE  = 1'b1;
  localparam logic WRITE_ENABLE = 1'b1;
  localparam logic RESET_ENABLE = 1'b1;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    READY = 1'b1
  } rf_state_t;

endpackage

// File: rtl/register_file_if.sv
// Bus bundle for register_file: packed read and write ports plus the ready flag.
// The datapath side uses master and the register file uses slave.
interface register_file_if
  import register_file_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int NUM_READ   = 2,
  parameter int NUM_WRITE  = 1
);

  logic                            ready;
  logic [NUM_READ-1:0]             read_enable;
  logic [NUM_READ*ADDR_WIDTH-1:0]  read_address;
  logic [NUM_READ*DATA_WIDTH-1:0]  read_data;
  logic [NUM_WRITE-1:0]            write_enable;
  logic [NUM_WRITE*ADDR_WIDTH-1:0] write_address;
  logic [NUM_WRITE*DATA_WIDTH-1:0] write_data;

  modport master (
    input  ready,
    input  read_data,
    output read_enable,
    output read_address,
    output write_enable,
    output write_address,
    output write_data
  );

  modport slave (
    output ready,
    output read_data,
    input  read_enable,
    input  read_address,
    input  write_enable,
    input  write_address,
    input  write_data
  );

endinterface

// File: rtl/register_file_read_port.sv
// One combinational read port: address decode, zero/enable gating and, when
// REGISTER_FILE_BYPASS_EN is defined, same-cycle forwarding from the write ports.
module register_file_read_port
  import register_file_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int NUM_WRITE  = 1,
  parameter int DEPTH      = 2 ** ADDR_WIDTH
) (
  input  logic                            active,
  input  logic                            enable,
  input  logic [ADDR_WIDTH-1:0]           address,
  input  logic [DATA_WIDTH-1:0]           storage [DEPTH],
  input  logic [NUM_WRITE-1:0]            write_enable,
  input  logic [NUM_WRITE*ADDR_WIDTH-1:0] write_address,
  input  logic [NUM_WRITE*DATA_WIDTH-1:0] write_data,
  output logic [DATA_WIDTH-1:0]           data
);

`ifdef REGISTER_FILE_BYPASS_EN
  always_comb begin
    data = '0;
    if (active && enable == READ_ENABLE && address != '0) begin
      data = storage[address];
      // Ascending scan so the highest-index matching write port wins.
      for (int w = 0; w < NUM_WRITE; w++) begin
        if (write_enable[w] == WRITE_ENABLE &&
            write_address[w*ADDR_WIDTH +: ADDR_WIDTH] == address) begin
          data = write_data[w*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end
`else
  logic unused_bypass;
  assign unused_bypass = ^{write_enable, write_address, write_data};

  always_comb begin
    data = '0;
    if (active && enable == READ_ENABLE && address != '0) begin
      data = storage[address];
    end
  end
`endif

endmodule

// File: rtl/register_file.sv
// Multi-port register file with r0 hardwired to zero and a post-reset clear sweep.
// Define REGISTER_FILE_BYPASS_EN to forward same-cycle writes to the read ports.
module register_file
  import register_file_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int NUM_READ   = 2,
  parameter int NUM_WRITE  = 1
) (
  input logic            clock,
  input logic            reset,
  register_file_if.slave bus
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  rf_state_t             state_reg;
  rf_state_t             state_next;
  logic [ADDR_WIDTH-1:0] clear_index_reg;
  logic [ADDR_WIDTH-1:0] clear_index_next;
  logic                  ready_flag;

  logic [DATA_WIDTH-1:0] storage [DEPTH];
  logic [DATA_WIDTH-1:0] port_data [NUM_READ];

  always_ff @(posedge clock) begin
    if (reset == RESET_ENABLE) begin
      state_reg       <= CLEAR;
      clear_index_reg <= ADDR_WIDTH'(1);
    end else begin
      state_reg       <= state_next;
      clear_index_reg <= clear_index_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    clear_index_next = clear_index_reg;
    if (state_reg == CLEAR) begin
      clear_index_next = clear_index_reg + 1'b1;
      if (clear_index_reg == ADDR_WIDTH'(DEPTH - 1)) begin
        state_next = READY;
      end
    end
  end

  always_comb begin
    ready_flag = (state_reg == READY);
  end

  assign bus.ready = ready_flag;

  // Entry 0 is never written; every read port gates address 0 to zero instead.
  always_ff @(posedge clock) begin
    if (reset != RESET_ENABLE) begin
      if (state_reg == CLEAR) begin
        storage[clear_index_reg] <= '0;
      end else begin
        for (int w = 0; w < NUM_WRITE; w++) begin
          if (bus.write_enable[w] == WRITE_ENABLE &&
              bus.write_address[w*ADDR_WIDTH +: ADDR_WIDTH] != '0) begin
            storage[bus.write_address[w*ADDR_WIDTH +: ADDR_WIDTH]] <=
              bus.write_data[w*DATA_WIDTH +: DATA_WIDTH];
          end
        end
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_READ; gi++) begin : g_read
      register_file_read_port #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_WRITE  (NUM_WRITE),
        .DEPTH      (DEPTH)
      ) u_read_port (
        .active        (ready_flag),
        .enable        (bus.read_enable[gi]),
        .address       (bus.read_address[gi*ADDR_WIDTH +: ADDR_WIDTH]),
        .storage       (storage),
        .write_enable  (bus.write_enable),
        .write_address (bus.write_address),
        .write_data    (bus.write_data),
        .data          (port_data[gi])
      );
      assign bus.read_data[gi*DATA_WIDTH +: DATA_WIDTH] = port_data[gi];
    end
  endgenerate

endmodule
